// File: rtl/wb_bram_ctrl_if.sv
// Wishbone classic-cycle bus bundle between a bus master and wb_bram_ctrl.
// The word address is one bit narrower than the BRAM address because each bus word spans two entries.
interface wb_bram_ctrl_if #(
    parameter int ADDRWIDTHA = 8
) ();
    logic                  wb_cyc;
    logic                  wb_stb;
    logic                  wb_we;
    logic [ADDRWIDTHA-2:0] wb_adr;
    logic [3:0]            wb_sel;
    logic [31:0]           wb_dat_w;
    logic [31:0]           wb_dat_r;
    logic                  wb_ack;

    modport master (
        output wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_dat_w,
        input  wb_dat_r, wb_ack
    );

    modport slave (
        input  wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_dat_w,
        output wb_dat_r, wb_ack
    );
endinterface

// File: rtl/wb_bram_ctrl.sv
// Wishbone slave that maps 32-bit byte-selectable words onto pairs of 16-bit BRAM port A entries.
// Partial writes use read-modify-write because port A has no byte enables.
module wb_bram_ctrl #(
    parameter int ADDRWIDTHA = 8,
    parameter int WIDTHA     = 16,
    parameter int WB_DW      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    wb_bram_ctrl_if.slave         wb,
    output logic                  busy,
    output logic                  bram_ena,
    output logic                  bram_we,
    output logic [ADDRWIDTHA-1:0] bram_addr,
    output logic [WIDTHA-1:0]     bram_di,
    input  logic [WIDTHA-1:0]     bram_do
);

    typedef enum logic [2:0] {
        IDLE, RD_LO, RD_HI, RD_LAST, WR_LO, WR_HI, ACK
    } state_t;

    state_t state, nextState;

    logic [ADDRWIDTHA-2:0] adrQ;
    logic                  weQ;
    logic [3:0]            selQ;
    logic [WB_DW-1:0]      wdata;
    logic [WB_DW-1:0]      rdata;
    logic [WB_DW-1:0]      datR;
    logic                  half;

    function automatic logic [WB_DW-1:0] mergeBytes(
        input logic [WB_DW-1:0] oldWord,
        input logic [WB_DW-1:0] newWord,
        input logic [3:0]       sel
    );
        logic [WB_DW-1:0] merged;
        merged = oldWord;
        for (int k = 0; k < 4; k++) begin
            if (sel[k]) merged[8*k +: 8] = newWord[8*k +: 8];
        end
        return merged;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    // Dropping wb_cyc only suppresses the acknowledge; BRAM operations always run to completion.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (wb.wb_cyc && wb.wb_stb) begin
                    if (!wb.wb_we)              nextState = RD_LO;
                    else if (wb.wb_sel == 4'hF) nextState = WR_LO;
                    else if (wb.wb_sel == 4'h0) nextState = ACK;
                    else                        nextState = RD_LO;
                end
            end
            RD_LO:   nextState = RD_HI;
            RD_HI:   nextState = RD_LAST;
            RD_LAST: nextState = weQ ? WR_LO : (wb.wb_cyc ? ACK : IDLE);
            WR_LO:   nextState = WR_HI;
            WR_HI:   nextState = wb.wb_cyc ? ACK : IDLE;
            ACK:     nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            adrQ  <= '0;
            weQ   <= 1'b0;
            selQ  <= '0;
            wdata <= '0;
            rdata <= '0;
            datR  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (wb.wb_cyc && wb.wb_stb) begin
                        adrQ  <= wb.wb_adr;
                        weQ   <= wb.wb_we;
                        selQ  <= wb.wb_sel;
                        wdata <= wb.wb_dat_w;
                    end
                end
                RD_HI: rdata[15:0] <= bram_do;
                RD_LAST: begin
                    rdata[31:16] <= bram_do;
                    if (weQ) wdata <= mergeBytes({bram_do, rdata[15:0]}, wdata, selQ);
                    else     datR  <= {bram_do, rdata[15:0]};
                end
                default: ;
            endcase
        end
    end

    // BRAM controls come only from state and latched registers, never from live bus inputs.
    always_comb begin
        bram_ena = (state == RD_LO) || (state == RD_HI) || (state == WR_LO) || (state == WR_HI);
        bram_we  = (state == WR_LO) || (state == WR_HI);
        half     = (state == RD_HI) || (state == WR_HI);
        bram_di  = '0;
        if (state == WR_LO) bram_di = wdata[15:0];
        if (state == WR_HI) bram_di = wdata[31:16];
    end

    assign bram_addr   = {adrQ, half};
    assign busy        = (state != IDLE);
    assign wb.wb_ack   = (state == ACK);
    assign wb.wb_dat_r = datR;

endmodule

// File: tb/tb_wb_bram_ctrl.sv
// Self-checking bench for wb_bram_ctrl with a behavioural registered-output BRAM on port A.
module tb_wb_bram_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        busy, bram_ena, bram_we;
    logic [7:0]  bram_addr;
    logic [15:0] bram_di, bram_do;

    wb_bram_ctrl_if #(.ADDRWIDTHA(8)) bus ();

    wb_bram_ctrl #(.ADDRWIDTHA(8), .WIDTHA(16), .WB_DW(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .wb        (bus),
        .busy      (busy),
        .bram_ena  (bram_ena),
        .bram_we   (bram_we),
        .bram_addr (bram_addr),
        .bram_di   (bram_di),
        .bram_do   (bram_do)
    );

    always #5 clk = ~clk;

    logic [15:0] mem    [256];
    logic [15:0] refMem [256];

    always @(posedge clk) begin
        if (bram_ena) begin
            if (bram_we) mem[bram_addr] <= bram_di;
            bram_do <= mem[bram_addr];
        end
    end

    bit   logOn = 1'b0;
    int   addrLog[$];
    always @(negedge clk) if (logOn && bram_ena) addrLog.push_back(int'(bram_addr));

    logic [31:0] expQ[$];
    int nCmp = 0;
    int nFail = 0;

    function automatic logic [31:0] refWord(input int adr);
        return {refMem[2*adr+1], refMem[2*adr]};
    endfunction

    function automatic void refWrite(input int adr, input logic [31:0] dat, input logic [3:0] sel);
        logic [31:0] mask, w;
        mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
        w = (refWord(adr) & ~mask) | (dat & mask);
        refMem[2*adr]   = w[15:0];
        refMem[2*adr+1] = w[31:16];
    endfunction

    // Drives one request and returns the negedge count at which it finished.
    task automatic xfer(input bit we, input int adr, input logic [3:0] sel, input logic [31:0] dat,
                        input int dropAt, input bit chain,
                        output int lat, output int weCnt, output bit acked);
        if (!chain) @(negedge clk);
        bus.wb_cyc = 1'b1; bus.wb_stb = 1'b1; bus.wb_we = we;
        bus.wb_adr = 7'(adr); bus.wb_sel = sel; bus.wb_dat_w = dat;
        if (we) refWrite(adr, dat, sel);
        else    expQ.push_back(refWord(adr));
        lat = -1; weCnt = 0; acked = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (bram_we) weCnt++;
            if (n == dropAt) begin bus.wb_cyc = 1'b0; bus.wb_stb = 1'b0; end
            if (bus.wb_ack) begin
                acked = 1'b1; lat = n;
                bus.wb_cyc = 1'b0; bus.wb_stb = 1'b0;
                break;
            end
            if (dropAt > 0 && n > 1 && !busy) begin lat = n; break; end
        end
        bus.wb_cyc = 1'b0; bus.wb_stb = 1'b0;
    endtask

    task automatic popRead(input string name, input bit acked);
        logic [31:0] e;
        e = (expQ.size() > 0) ? expQ.pop_front() : 32'hx;
        nCmp++;
        if (!acked || bus.wb_dat_r !== e) begin
            nFail++;
            $display("FAIL %s: got %h (acked=%0d) want %h", name, bus.wb_dat_r, acked, e);
        end
    endtask

    task automatic test_reset;
        int lat, wc; bit ak;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        nCmp++; if ({bus.wb_ack, busy, bram_ena, bram_we} !== 4'b0) begin nFail++;
            $display("FAIL reset_ctl: got %b want 0000", {bus.wb_ack, busy, bram_ena, bram_we}); end
        nCmp++; if (bram_addr !== 8'd0 || bram_di !== 16'd0) begin nFail++;
            $display("FAIL reset_bram: got addr %h di %h want 0 0", bram_addr, bram_di); end
        nCmp++; if (bus.wb_dat_r !== 32'd0) begin nFail++;
            $display("FAIL reset_datr: got %h want 0", bus.wb_dat_r); end
        rst = 1'b0;
        xfer(1, 3, 4'hF, 32'hCAFEF00D, 0, 0, lat, wc, ak);
        xfer(0, 3, 4'hF, 32'h0, 0, 0, lat, wc, ak);
        popRead("pre_reset_read", ak);
        // Interrupt a full write while it is writing the upper half.
        @(negedge clk);
        bus.wb_cyc = 1'b1; bus.wb_stb = 1'b1; bus.wb_we = 1'b1;
        bus.wb_adr = 7'd3; bus.wb_sel = 4'hF; bus.wb_dat_w = 32'h12345678;
        repeat (2) @(negedge clk);
        nCmp++; if (!(bram_we && bram_addr == 8'd7)) begin nFail++;
            $display("FAIL rst_wrhi_state: got we %b addr %0d want 1 7", bram_we, bram_addr); end
        rst = 1'b1;
        #1;
        nCmp++; if ({bus.wb_ack, bram_ena, busy} !== 3'b0) begin nFail++;
            $display("FAIL rst_mid_ctl: got %b want 000", {bus.wb_ack, bram_ena, busy}); end
        nCmp++; if (bus.wb_dat_r !== 32'd0) begin nFail++;
            $display("FAIL rst_mid_datr: got %h want 0", bus.wb_dat_r); end
        @(negedge clk);
        rst = 1'b0; bus.wb_cyc = 1'b0; bus.wb_stb = 1'b0;
        refMem[6] = 16'h5678;
        xfer(0, 3, 4'hF, 32'h0, 0, 0, lat, wc, ak);
        nCmp++; if (lat != 4) begin nFail++; $display("FAIL post_reset_lat: got %0d want 4", lat); end
        popRead("post_reset_read", ak);
    endtask

    task automatic test_full_write;
        int lat, wc; bit ak;
        @(negedge clk);
        bus.wb_cyc = 1'b1; bus.wb_stb = 1'b1; bus.wb_we = 1'b1;
        bus.wb_adr = 7'd5; bus.wb_sel = 4'hF; bus.wb_dat_w = 32'hDEADBEEF;
        refWrite(5, 32'hDEADBEEF, 4'hF);
        repeat (2) @(negedge clk);
        nCmp++; if (mem[10] !== 16'hBEEF || mem[11] === 16'hDEAD) begin nFail++;
            $display("FAIL fw_lo_first: got %h/%h want BEEF/old", mem[10], mem[11]); end
        @(negedge clk);
        nCmp++; if (bus.wb_ack !== 1'b1 || mem[11] !== 16'hDEAD) begin nFail++;
            $display("FAIL fw_ack_e2: got ack %b hi %h want 1 DEAD", bus.wb_ack, mem[11]); end
        bus.wb_cyc = 1'b0; bus.wb_stb = 1'b0;
        xfer(0, 5, 4'hF, 32'h0, 0, 0, lat, wc, ak);
        nCmp++; if (lat != 4) begin nFail++; $display("FAIL rd_lat: got %0d want 4", lat); end
        popRead("fw_readback", ak);
    endtask

    task automatic test_rmw;
        int lat, wc; bit ak;
        xfer(1, 5, 4'b0101, 32'h11223344, 0, 0, lat, wc, ak);
        nCmp++; if (lat != 6 || wc != 2) begin nFail++;
            $display("FAIL rmw_timing: got lat %0d we %0d want 6 2", lat, wc); end
        nCmp++; if (mem[10] !== 16'hBE44 || mem[11] !== 16'hDE22) begin nFail++;
            $display("FAIL rmw_mem: got %h/%h want BE44/DE22", mem[10], mem[11]); end
        xfer(0, 5, 4'h0, 32'h0, 0, 0, lat, wc, ak);
        popRead("rmw_readback", ak);
    endtask

    task automatic test_sel0;
        int lat, wc; bit ak;
        xfer(1, 5, 4'h0, 32'hFFFFFFFF, 0, 0, lat, wc, ak);
        nCmp++; if (lat != 1 || wc != 0) begin nFail++;
            $display("FAIL sel0_timing: got lat %0d we %0d want 1 0", lat, wc); end
        nCmp++; if ({mem[11], mem[10]} !== refWord(5)) begin nFail++;
            $display("FAIL sel0_mem: got %h want %h", {mem[11], mem[10]}, refWord(5)); end
    endtask

    task automatic test_abort;
        int lat, wc; bit ak;
        xfer(1, 9, 4'hF, 32'hAABBCCDD, 0, 0, lat, wc, ak);
        xfer(1, 9, 4'b0001, 32'h00000011, 2, 0, lat, wc, ak);
        nCmp++; if (ak !== 1'b0 || lat != 6 || wc != 2) begin nFail++;
            $display("FAIL abort_flow: got ack %0d busyEnd %0d we %0d want 0 6 2", ak, lat, wc); end
        nCmp++; if (mem[18] !== 16'hCC11 || mem[19] !== 16'hAABB) begin nFail++;
            $display("FAIL abort_mem: got %h/%h want CC11/AABB", mem[18], mem[19]); end
    endtask

    task automatic test_back_to_back;
        int lat, wc; bit ak;
        xfer(1, 127, 4'hF, 32'h7F7F0102, 0, 0, lat, wc, ak);
        xfer(1, 0, 4'hF, 32'h0A0B0C0D, 0, 0, lat, wc, ak);
        addrLog.delete();
        logOn = 1'b1;
        xfer(0, 127, 4'hF, 32'h0, 0, 0, lat, wc, ak);
        popRead("b2b_first", ak);
        xfer(0, 0, 4'hF, 32'h0, 0, 1, lat, wc, ak);
        logOn = 1'b0;
        nCmp++; if (lat != 5) begin nFail++; $display("FAIL b2b_lat: got %0d want 5", lat); end
        popRead("b2b_second", ak);
        nCmp++;
        if (addrLog.size() != 4 || addrLog[0] != 254 || addrLog[1] != 255 ||
            addrLog[2] != 0 || addrLog[3] != 1) begin
            nFail++;
            $display("FAIL b2b_addr: got %p want '{254,255,0,1}", addrLog);
        end
    endtask

    initial begin
        bus.wb_cyc = 1'b0; bus.wb_stb = 1'b0; bus.wb_we = 1'b0;
        bus.wb_adr = '0; bus.wb_sel = '0; bus.wb_dat_w = '0;
        for (int i = 0; i < 256; i++) begin mem[i] = 16'h0; refMem[i] = 16'h0; end
        bram_do = 16'h0;
        test_reset();
        test_full_write();
        test_rmw();
        test_sel0();
        test_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule
